fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if_id_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-pipeline definitions: fetch FSM encoding, NOP word, default reset PC
// and small address helpers used by the fetch stage and its ID register.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; an unstalled,
// unloaded cycle means decode consumed the entry, so valid drops.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc_plus4;
    end else if (!hold) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE/REQ/DROP/HOLD request FSM feeding the IF/ID register.
// Define FETCH_SKID_BUF_EN to add a one-entry skid buffer that absorbs an ack under stall.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;   // redirect target parked while DROP drains the old request
  logic [31:0]  redirect_tgt;
  logic         id_can_take;
  logic         id_flush;
  logic         id_load;
  logic [31:0]  id_load_instr;
  logic [31:0]  id_load_pc4;

`ifdef FETCH_SKID_BUF_EN
  // Buffer occupancy is implied by ST_HOLD, so no separate valid flop.
  logic [31:0]  sbuf_instr_q, sbuf_instr_d;
  logic [31:0]  sbuf_pc4_q, sbuf_pc4_d;
`endif

  assign redirect_tgt = word_align(redirect_pc);
  assign id_can_take  = !id_valid || !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    id_flush      = 1'b0;
    id_load       = 1'b0;
    id_load_instr = imem_rdata;
    id_load_pc4   = pc_plus4(pc_q);
`ifdef FETCH_SKID_BUF_EN
    sbuf_instr_d  = sbuf_instr_q;
    sbuf_pc4_d    = sbuf_pc4_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
`ifdef FETCH_SKID_BUF_EN
        imem_req = 1'b1;
`else
        imem_req = id_can_take;
`endif
        if (redirect) begin
          id_flush = 1'b1;
          // Only an issued, unanswered request needs draining.
          if (imem_req && !imem_ack) begin
            tgt_d   = redirect_tgt;
            state_d = ST_DROP;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (imem_req && imem_ack) begin
          pc_d = pc_plus4(pc_q);
          if (id_can_take) begin
            id_load = 1'b1;
          end
`ifdef FETCH_SKID_BUF_EN
          else begin
            sbuf_instr_d = imem_rdata;
            sbuf_pc4_d   = pc_plus4(pc_q);
            state_d      = ST_HOLD;
          end
`endif
        end
      end

      ST_DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          id_flush = 1'b1;
          tgt_d    = redirect_tgt;
        end
        if (imem_ack) begin
          pc_d    = redirect ? redirect_tgt : tgt_q;
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
`ifdef FETCH_SKID_BUF_EN
        if (redirect) begin
          id_flush = 1'b1;
          pc_d     = redirect_tgt;
          state_d  = ST_REQ;
        end else if (!stall) begin
          id_load       = 1'b1;
          id_load_instr = sbuf_instr_q;
          id_load_pc4   = sbuf_pc4_q;
          state_d       = ST_REQ;
        end
`else
        state_d = ST_REQ;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef FETCH_SKID_BUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf_instr_q <= NOP_INSTR;
      sbuf_pc4_q   <= 32'h0000_0000;
    end else begin
      sbuf_instr_q <= sbuf_instr_d;
      sbuf_pc4_q   <= sbuf_pc4_d;
    end
  end
`endif

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (id_flush),
    .load          (id_load),
    .hold          (stall),
    .load_instr    (id_load_instr),
    .load_pc_plus4 (id_load_pc4),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4)
  );

endmodule
